// File: rtl/nios_systemv2_leds_if.sv
// Avalon-MM slave bus for the LED output port: word address, select, active-low write strobe,
// 32-bit write data and registered 32-bit read data.
`timescale 1ns/1ps
interface nios_systemv2_leds_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_systemv2_leds.sv
// Eight-LED Avalon-MM output port: data register with set/clear strobes plus a prescaled blink mask.
// Latency: writes visible after the sampling edge, reads registered one cycle; backpressure: none, no wait states.
`timescale 1ns/1ps
module nios_systemv2_leds #(
    parameter logic [7:0]  RESET_VALUE = 8'h00,
    parameter int unsigned BLINK_DIV   = 25_000_000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    nios_systemv2_leds_if.slave       bus,
    output logic [7:0]                out_port
);

    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(BLINK_DIV - 1);

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_BLINK = 2'd1;
    localparam logic [1:0] ADDR_SET   = 2'd2;
    localparam logic [1:0] ADDR_CLR   = 2'd3;

    logic [7:0]    data_q,     data_d;
    logic [7:0]    mask_q,     mask_d;
    logic [CW-1:0] div_cnt_q,  div_cnt_d;
    logic          phase_q,    phase_d;
    logic [31:0]   readdata_q, readdata_d;

    logic       we;
    logic       wrap;
    logic       restart;
    logic [7:0] wdat;
    logic       wdata_unused;

    assign we           = bus.chipselect & ~bus.write_n;
    assign wdat         = bus.writedata[7:0];
    assign wdata_unused = ^bus.writedata[31:8];
    assign wrap         = (div_cnt_q == DIV_LAST);
    assign restart      = we && (bus.address == ADDR_BLINK);

    assign out_port     = data_q ^ ({8{phase_q}} & mask_q);
    assign bus.readdata = readdata_q;

    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        if (we) begin
            case (bus.address)
                ADDR_DATA:  data_d = wdat;
                ADDR_BLINK: mask_d = wdat;
                ADDR_SET:   data_d = data_q | wdat;
                ADDR_CLR:   data_d = data_q & ~wdat;
                default:    data_d = data_q;
            endcase
        end
    end

    // A mask write realigns the blink so software sees a full un-inverted half-period first.
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        phase_d   = phase_q;
        if (restart) begin
            div_cnt_d = '0;
            phase_d   = 1'b0;
        end else if (wrap) begin
            div_cnt_d = '0;
            phase_d   = ~phase_q;
        end
    end

    always_comb begin
        readdata_d = 32'd0;
        case (bus.address)
            ADDR_DATA:  readdata_d = {24'd0, data_q};
            ADDR_BLINK: readdata_d = {24'd0, mask_q};
            ADDR_SET:   readdata_d = {24'd0, out_port};
            ADDR_CLR:   readdata_d = {31'd0, phase_q};
            default:    readdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            mask_q     <= 8'd0;
            div_cnt_q  <= '0;
            phase_q    <= 1'b0;
            readdata_q <= 32'd0;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            div_cnt_q  <= div_cnt_d;
            phase_q    <= phase_d;
            readdata_q <= readdata_d;
        end
    end

endmodule
